// File: rtl/excess3_pkg.sv
// excess3_pkg: shared Excess-3 code limits and FSM state encoding
package excess3_pkg;
  localparam logic [3:0] E3_OFFSET = 4'd3;
  localparam logic [3:0] E3_MIN = 4'd3;
  localparam logic [3:0] E3_MAX = 4'd12;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_CONV = 1'b1;
  typedef enum logic {IDLE = ST_IDLE, CONV = ST_CONV} state_t;
endpackage

// File: rtl/excess3_digit_decode.sv
// excess3_digit_decode: one Excess-3 nibble to its decimal digit plus legality flag
module excess3_digit_decode
  import excess3_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] digit,
  output logic       valid
);
  assign digit = nibble - E3_OFFSET;
  assign valid = (nibble >= E3_MIN) && (nibble <= E3_MAX);
endmodule

// File: rtl/excess3_to_binary_decoder.sv
// excess3_to_binary_decoder: serial packed Excess-3 to binary, one digit per clock
module excess3_to_binary_decoder
  import excess3_pkg::*;
#(
  parameter int NDIGITS = 2,
  parameter int BIN_W = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   E,
  input  logic [4*NDIGITS-1:0]   X3_in,
  output logic                   busy,
  output logic [BIN_W-1:0]       Binary_result,
  output logic                   done,
  output logic                   err
);
  localparam int SW = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS) + 1;
  state_t state, state_nx;
  logic [SW-1:0] sr;
  logic [BIN_W-1:0] acc, acc_nx, res;
  logic [CW-1:0] cnt;
  logic err_acc, err_nx, last, dv;
  logic [3:0] dg;
  excess3_digit_decode u_dec (
    .nibble(sr[SW-1 -: 4]),
    .digit (dg),
    .valid (dv)
  );
  // next accumulator/error for the digit at the top of the shift register, and next state
  always_comb begin
    last = cnt == CW'(NDIGITS - 1);
    acc_nx = (acc << 3) + (acc << 1) + BIN_W'(dg);
    err_nx = err_acc | ~dv;
    state_nx = (state == IDLE) ? (E ? CONV : IDLE) : (last ? IDLE : CONV);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // datapath: latch digits on start, fold one digit per cycle, publish on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      err_acc <= 1'b0;
      res <= '0;
      err <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && E) begin
        sr <= X3_in;
        acc <= '0;
        cnt <= '0;
        err_acc <= 1'b0;
      end else if (state == CONV) begin
        sr <= sr << 4;
        acc <= acc_nx;
        err_acc <= err_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          res <= err_nx ? '0 : acc_nx;
          err <= err_nx;
          done <= 1'b1;
        end
      end
    end
  end
  assign busy = state == CONV;
  assign Binary_result = res;
endmodule

// File: tb/tb_excess3_to_binary_decoder.sv
// tb_excess3_to_binary_decoder: directed and random checks against a decimal reference model
module tb_excess3_to_binary_decoder;
  localparam int ND = 2;
  localparam int BW = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic e = 1'b0;
  logic [4*ND-1:0] x3 = '0;
  logic busy, done, err;
  logic [BW-1:0] res;
  int checks = 0;
  int errors = 0;
  excess3_to_binary_decoder #(.NDIGITS(ND), .BIN_W(BW)) dut (
    .clk(clk), .rst(rst), .E(e), .X3_in(x3),
    .busy(busy), .Binary_result(res), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [4*ND-1:0] x, output int r, output bit e_out);
    int v;
    int n;
    v = 0;
    e_out = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      n = int'(x[4*i +: 4]);
      if (n < 3 || n > 12) e_out = 1;
      v = v * 10 + (n - 3);
    end
    r = e_out ? 0 : v % (1 << BW);
  endfunction
  task automatic run(input logic [4*ND-1:0] x, input string tag);
    int r;
    bit me;
    model(x, r, me);
    e = 1'b1;
    x3 = x;
    @(negedge clk);
    e = 1'b0;
    x3 = ~x;
    for (int i = 0; i < ND; i++) begin
      chk({tag, " busy"}, int'(busy), 1);
      chk({tag, " early done"}, int'(done), 0);
      @(negedge clk);
    end
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " busy off"}, int'(busy), 0);
    chk({tag, " result"}, int'(res), r);
    chk({tag, " err"}, int'(err), int'(me));
    @(negedge clk);
    chk({tag, " pulse"}, int'(done), 0);
    chk({tag, " hold"}, int'(res), r);
  endtask
  initial begin
    logic [4*ND-1:0] rx;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst err", int'(err), 0);
    chk("rst result", int'(res), 0);
    run(8'h45, "t1_45");
    run(8'h33, "t2_33");
    run(8'hCC, "t2_CC");
    run(8'h3C, "t2_3C");
    run(8'h4F, "t3_4F");
    run(8'h20, "t3_20");
    run(8'h56, "t3_56");
    e = 1'b1;
    x3 = 8'h78;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4 busy", int'(busy), 1);
      if (k == 3) x3 = 8'h99;
      @(negedge clk);
      @(negedge clk);
      chk("t4 done", int'(done), 1);
      chk("t4 result", int'(res), 45);
    end
    @(negedge clk);
    e = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4 next done", int'(done), 1);
    chk("t4 next result", int'(res), 66);
    @(negedge clk);
    e = 1'b1;
    x3 = 8'h99;
    @(negedge clk);
    e = 1'b0;
    chk("t5 busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 busy", int'(busy), 0);
    chk("t5 done", int'(done), 0);
    chk("t5 result", int'(res), 0);
    chk("t5 err", int'(err), 0);
    repeat (3) begin
      @(negedge clk);
      chk("t5 no done", int'(done), 0);
    end
    run(8'h99, "t5_99");
    rst = 1'b1;
    e = 1'b1;
    x3 = 8'h45;
    @(negedge clk);
    rst = 1'b0;
    e = 1'b0;
    chk("t6 busy", int'(busy), 0);
    chk("t6 done", int'(done), 0);
    @(negedge clk);
    chk("t6 idle", int'(busy), 0);
    for (int i = 0; i < 40; i++) begin
      rx = 8'($urandom);
      if (i % 2 == 0) rx = {4'($urandom_range(12, 3)), 4'($urandom_range(12, 3))};
      run(rx, "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
